// File: rtl/bcd_cntr_pkg.sv
// rtl/bcd_cntr_pkg.sv - shared digit constants and load clamp helper for the BCD counter
package bcd_cntr_pkg;

  localparam int unsigned DIG_W = 4;
  localparam logic [DIG_W-1:0] DIG_MAX = 4'd9;
  localparam logic [DIG_W-1:0] DIG_MIN = 4'd0;

  // Codes 10..15 are not BCD; they are pulled down to the largest legal digit.
  function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] d);
    return (d > DIG_MAX) ? DIG_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit register with clear, load, increment and decrement
module bcd_digit
  import bcd_cntr_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [DIG_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [DIG_W-1:0] q,
  output logic             is_max,
  output logic             is_min
);

  logic [DIG_W-1:0] q_q;
  logic [DIG_W-1:0] q_d;

  assign q      = q_q;
  assign is_max = (q_q == DIG_MAX);
  assign is_min = (q_q == DIG_MIN);

  // Next digit value: clear beats load beats a step; 9 and 0 wrap into each other.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = DIG_MIN;
    end else if (load) begin
      q_d = clamp_digit(load_val);
    end else if (inc) begin
      q_d = is_max ? DIG_MIN : q_q + 4'd1;
    end else if (dec) begin
      q_d = is_min ? DIG_MAX : q_q - 4'd1;
    end
  end

  // Digit storage, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= DIG_MIN;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_sync_updn_cntr.sv
// rtl/bcd_sync_updn_cntr.sv - NDIG-digit synchronous BCD up/down counter; BCD_CNTR_SAT_EN selects saturation instead of wrap
module bcd_sync_updn_cntr
  import bcd_cntr_pkg::*;
#(
  parameter int unsigned NDIG = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DIG_W*NDIG-1:0] load_val,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  output logic [DIG_W*NDIG-1:0] count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  logic [NDIG-1:0] is_max;
  logic [NDIG-1:0] is_min;
  logic [NDIG-1:0] inc;
  logic [NDIG-1:0] dec;
  logic [NDIG-1:0] digit_bad;
  // carry[i] / borrow[i]: every digit below i sits at 9 / at 0.
  logic [NDIG:0]   carry;
  logic [NDIG:0]   borrow;
  logic            all_max;
  logic            all_min;
  logic            step_up;
  logic            step_dn;

  logic ovf_q, ovf_d;
  logic load_err_q, load_err_d;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;
  assign all_max   = carry[NDIG];
  assign all_min   = borrow[NDIG];

  assign tc = cnt_en & (up_dn ? all_max : all_min);

`ifdef BCD_CNTR_SAT_EN
  // At the end of range the step is suppressed so every digit holds.
  assign step_up = cnt_en &  up_dn & ~all_max;
  assign step_dn = cnt_en & ~up_dn & ~all_min;
`else
  assign step_up = cnt_en &  up_dn;
  assign step_dn = cnt_en & ~up_dn;
`endif

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign carry[i+1]   = carry[i]  & is_max[i];
    assign borrow[i+1]  = borrow[i] & is_min[i];
    assign inc[i]       = step_up & carry[i];
    assign dec[i]       = step_dn & borrow[i];
    assign digit_bad[i] = (load_val[DIG_W*i +: DIG_W] > DIG_MAX);

    bcd_digit u_digit (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[DIG_W*i +: DIG_W]),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .q        (count[DIG_W*i +: DIG_W]),
      .is_max   (is_max[i]),
      .is_min   (is_min[i])
    );
  end

  // Sticky overflow set by an end-of-range step; load_err pulses only on a clamping load.
  always_comb begin
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (load) begin
      load_err_d = |digit_bad;
    end else if (tc) begin
      ovf_d = 1'b1;
    end
  end

  // Status flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_sync_updn_cntr.sv
// tb/tb_bcd_sync_updn_cntr.sv - randomized and directed check of the BCD counter against an integer model
module tb_bcd_sync_updn_cntr;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;
  localparam int MOD  = 1000;

  logic         clk = 1'b0;
  logic         rstn;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         cnt_en;
  logic         up_dn;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;
  logic         load_err;

  int checks   = 0;
  int failures = 0;

  int m_val;
  bit m_ovf;
  bit m_lerr;

  always #5 clk = ~clk;

  bcd_sync_updn_cntr #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .cnt_en   (cnt_en),
    .up_dn    (up_dn),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .load_err (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  // Reference behaviour on an edge, using decimal arithmetic on the count value.
  task automatic model_edge(input bit c, input bit l, input logic [W-1:0] lv,
                            input bit en, input bit ud);
    int d, v, p;
    bit err;
    if (c) begin
      m_val = 0; m_ovf = 0; m_lerr = 0;
    end else if (l) begin
      v = 0; p = 1; err = 0;
      for (int i = 0; i < NDIG; i++) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin d = 9; err = 1; end
        v += d * p;
        p *= 10;
      end
      m_val = v; m_lerr = err;
    end else begin
      m_lerr = 0;
      if (en) begin
        if (ud) begin
          if (m_val == MOD - 1) begin
            m_ovf = 1;
`ifndef BCD_CNTR_SAT_EN
            m_val = 0;
`endif
          end else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin
            m_ovf = 1;
`ifndef BCD_CNTR_SAT_EN
            m_val = MOD - 1;
`endif
          end else m_val = m_val - 1;
        end
      end
    end
  endtask

  // One clock: drive inputs, check tc combinationally, clock, check registered outputs.
  task automatic step(input string tag, input bit c, input bit l, input logic [W-1:0] lv,
                      input bit en, input bit ud);
    bit exp_tc;
    clr = c; load = l; load_val = lv; cnt_en = en; up_dn = ud;
    #1;
    exp_tc = en && (ud ? (m_val == MOD - 1) : (m_val == 0));
    check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    @(posedge clk);
    model_edge(c, l, lv, en, ud);
    #1;
    check({tag, ".count"}, 32'(count), 32'(to_bcd(m_val)));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".load_err"}, 32'(load_err), 32'(m_lerr));
  endtask

  initial begin
    logic [W-1:0] lv;
    rstn = 1'b0; clr = 0; load = 0; load_val = '0; cnt_en = 0; up_dn = 0;
    m_val = 0; m_ovf = 0; m_lerr = 0;
    #12;
    check("rst.count", 32'(count), 32'h0);
    check("rst.ovf", 32'(ovf), 32'h0);
    check("rst.load_err", 32'(load_err), 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-count.
    step("r_ld", 0, 1, 12'h457, 0, 0);
    step("r_up", 0, 0, '0, 1, 1);
    step("r_up", 0, 0, '0, 1, 1);
    #2 rstn = 1'b0;
    #1;
    m_val = 0; m_ovf = 0; m_lerr = 0;
    check("arst.count", 32'(count), 32'h0);
    check("arst.ovf", 32'(ovf), 32'h0);
    check("arst.load_err", 32'(load_err), 32'h0);
    cnt_en = 0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Up carry chain.
    step("up_ld", 0, 1, 12'h098, 0, 1);
    for (int i = 0; i < 3; i++) step("up_chain", 0, 0, '0, 1, 1);

    // Up wrap / saturate and sticky ovf.
    step("wr_ld", 0, 1, 12'h999, 0, 1);
    for (int i = 0; i < 3; i++) step("up_wrap", 0, 0, '0, 1, 1);
    step("wr_clr", 1, 0, '0, 0, 0);

    // Down borrow and wrap.
    step("dn_ld", 0, 1, 12'h100, 0, 0);
    for (int i = 0; i < 2; i++) step("dn_chain", 0, 0, '0, 1, 0);
    step("dz_ld", 0, 1, 12'h000, 0, 0);
    step("dn_wrap", 0, 0, '0, 1, 0);

    // Load clamp and priority.
    step("clamp", 0, 1, 12'h3A7, 0, 0);
    step("clamp_nx", 0, 0, '0, 0, 0);
    step("clamp2", 0, 1, 12'hFBC, 1, 1);
    step("prio", 1, 1, 12'h555, 1, 1);
    step("ld_over_en", 0, 1, 12'h123, 1, 1);

    // Hold with up_dn toggling.
    step("hold_ld", 0, 1, 12'h512, 0, 0);
    for (int i = 0; i < 5; i++) step("hold", 0, 0, '0, 0, i[0]);

    // Randomized traffic, biased toward the range ends.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: lv = 12'h999;
        1: lv = 12'h000;
        2: lv = to_bcd(int'($urandom_range(0, MOD - 1)));
        default: lv = W'($urandom);
      endcase
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0), lv,
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
